// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter : two-requester round-robin arbiter driving one RAM port
// Rev 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int AddrWidth   = 30,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req_i,
  input  logic                   m0_wr_i,
  input  logic [AddrWidth-1:0]   m0_addr_i,
  input  logic [DataWidth-1:0]   m0_wdata_i,
  input  logic [DataWidth/8-1:0] m0_be_i,
  output logic                   m0_gnt_o,
  output logic                   m0_rvalid_o,
  output logic [DataWidth-1:0]   m0_rdata_o,
  input  logic                   m1_req_i,
  input  logic                   m1_wr_i,
  input  logic [AddrWidth-1:0]   m1_addr_i,
  input  logic [DataWidth-1:0]   m1_wdata_i,
  input  logic [DataWidth/8-1:0] m1_be_i,
  output logic                   m1_gnt_o,
  output logic                   m1_rvalid_o,
  output logic [DataWidth-1:0]   m1_rdata_o,
  output logic [AddrWidth-1:0]   ram_addr_o,
  output logic [DataWidth-1:0]   ram_wdata_o,
  output logic [DataWidth/8-1:0] ram_be_o,
  output logic                   ram_wren_o,
  input  logic [DataWidth-1:0]   ram_rdata_i
);

  localparam int         BE_WIDTH  = DataWidth / 8;
  localparam logic [2:0] LAT_COUNT = 3'(ReadLatency);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e                 state_q;
  logic [2:0]             cnt_q;
  logic                   last_q;   // 1: m1 was granted most recently
  logic                   owner_q;  // 1: outstanding read belongs to m1
  logic [AddrWidth-1:0]   addr_q;

  logic                   any_req;
  logic                   sel;
  logic                   grant;
  logic                   rd_fire;
  logic                   win_wr;
  logic [AddrWidth-1:0]   win_addr;
  logic [DataWidth-1:0]   win_wdata;
  logic [BE_WIDTH-1:0]    win_be;

  always_comb begin
    any_req = m0_req_i | m1_req_i;
    // On a tie the requester not granted last wins; otherwise the lone requester.
    if (m0_req_i && m1_req_i) begin
      sel = ~last_q;
    end else begin
      sel = m1_req_i;
    end
    grant     = !rst && (state_q == ST_IDLE) && any_req;
    rd_fire   = !rst && (state_q == ST_WAIT) && (cnt_q == 3'd1);
    win_wr    = sel ? m1_wr_i    : m0_wr_i;
    win_addr  = sel ? m1_addr_i  : m0_addr_i;
    win_wdata = sel ? m1_wdata_i : m0_wdata_i;
    win_be    = sel ? m1_be_i    : m0_be_i;
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    ram_wren_o  = 1'b0;
    if (grant) begin
      ram_addr_o  = win_addr;
      ram_wdata_o = win_wdata;
      ram_be_o    = win_be;
      ram_wren_o  = win_wr;
    end else if (!rst && (state_q == ST_WAIT)) begin
      ram_addr_o  = addr_q;
    end
  end

  assign m0_gnt_o    = grant & ~sel;
  assign m1_gnt_o    = grant & sel;
  assign m0_rvalid_o = rd_fire & ~owner_q;
  assign m1_rvalid_o = rd_fire & owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            last_q <= sel;
            // Writes finish in the grant cycle; only reads occupy the port.
            if (!win_wr) begin
              owner_q <= sel;
              addr_q  <= win_addr;
              cnt_q   <= LAT_COUNT;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// Scoreboard bench: two arbiter instances (ReadLatency 1 and 3) with directed
// stimulus; expected grant/rvalid events are queued and matched by a monitor.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req   [2][2];
  logic        wr    [2][2];
  logic [29:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [3:0]  be    [2][2];
  logic        gnt   [2][2];
  logic        rvalid[2][2];
  logic [31:0] rdata [2][2];
  logic [29:0] ram_addr [2];
  logic [31:0] ram_wdata[2];
  logic [3:0]  ram_be   [2];
  logic        ram_wren [2];
  logic [31:0] ram_rdata[2];

  function automatic logic [31:0] fmem(input logic [29:0] a);
    if (a == 30'h20) return 32'h12345678;
    return ({2'b00, a} * 32'h9E3779B1) + 32'h1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_port_arbiter #(
      .AddrWidth(30), .DataWidth(32), .ReadLatency((g == 0) ? 1 : 3)
    ) u_dut (
      .clk(clk), .rst(rst),
      .m0_req_i(req[g][0]), .m0_wr_i(wr[g][0]), .m0_addr_i(addr[g][0]),
      .m0_wdata_i(wdata[g][0]), .m0_be_i(be[g][0]),
      .m0_gnt_o(gnt[g][0]), .m0_rvalid_o(rvalid[g][0]), .m0_rdata_o(rdata[g][0]),
      .m1_req_i(req[g][1]), .m1_wr_i(wr[g][1]), .m1_addr_i(addr[g][1]),
      .m1_wdata_i(wdata[g][1]), .m1_be_i(be[g][1]),
      .m1_gnt_o(gnt[g][1]), .m1_rvalid_o(rvalid[g][1]), .m1_rdata_o(rdata[g][1]),
      .ram_addr_o(ram_addr[g]), .ram_wdata_o(ram_wdata[g]), .ram_be_o(ram_be[g]),
      .ram_wren_o(ram_wren[g]), .ram_rdata_i(ram_rdata[g])
    );
    assign ram_rdata[g] = fmem(ram_addr[g]);
  end

  typedef struct {
    int          c;
    int          inst;
    int          kind;   // 0 = grant, 1 = rvalid
    int          who;
    logic        wren;
    logic [29:0] a;
    logic [31:0] wd;
    logic [3:0]  b;
    logic [31:0] rd;
  } ev_t;

  ev_t expq[$];

  task automatic exp_gnt(input int c, input int i, input int m, input logic wen,
                         input logic [29:0] a, input logic [31:0] wd, input logic [3:0] b);
    ev_t e;
    e.c = c; e.inst = i; e.kind = 0; e.who = m; e.wren = wen;
    e.a = a; e.wd = wd; e.b = b; e.rd = '0;
    expq.push_back(e);
  endtask

  task automatic exp_rv(input int c, input int i, input int m, input logic [31:0] d);
    ev_t e;
    e.c = c; e.inst = i; e.kind = 1; e.who = m; e.wren = 1'b0;
    e.a = '0; e.wd = '0; e.b = '0; e.rd = d;
    expq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic see(input int i, input int k, input int m);
    ev_t e;
    logic ok;
    n_chk++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: inst %0d m%0d at cycle %0d, expected none",
               (k == 0) ? "gnt" : "rvalid", i, m, cyc);
      return;
    end
    e  = expq.pop_front();
    ok = (e.c == cyc) && (e.inst == i) && (e.kind == k) && (e.who == m);
    if (k == 0)
      ok = ok && (ram_wren[i] === e.wren) && (ram_addr[i] === e.a) &&
           (ram_wdata[i] === e.wd) && (ram_be[i] === e.b);
    else
      ok = ok && (rdata[i][m] === e.rd);
    if (!ok) begin
      n_fail++;
      $display("FAIL event: got inst %0d kind %0d m%0d cyc %0d wren %b addr %h wd %h be %h rd %h; expected inst %0d kind %0d m%0d cyc %0d wren %b addr %h wd %h be %h rd %h",
               i, k, m, cyc, ram_wren[i], ram_addr[i], ram_wdata[i], ram_be[i], rdata[i][m],
               e.inst, e.kind, e.who, e.c, e.wren, e.a, e.wd, e.b, e.rd);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) if (gnt[i][m] === 1'b1) see(i, 0, m);
      for (int m = 0; m < 2; m++) if (rvalid[i][m] === 1'b1) see(i, 1, m);
      for (int m = 0; m < 2; m++)
        if (rvalid[i][m] !== 1'b1) chk("rdata_idle_zero", rdata[i][m], 32'h0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input int m, input logic rq, input logic w,
                       input logic [29:0] a, input logic [31:0] wd, input logic [3:0] b);
    req[i][m] = rq; wr[i][m] = w; addr[i][m] = a; wdata[i][m] = wd; be[i][m] = b;
  endtask

  task automatic chk_outs_zero(input string nm, input int i);
    chk({nm, "_gnt0"}, {31'h0, gnt[i][0]}, 32'h0);
    chk({nm, "_gnt1"}, {31'h0, gnt[i][1]}, 32'h0);
    chk({nm, "_rv0"}, {31'h0, rvalid[i][0]}, 32'h0);
    chk({nm, "_rv1"}, {31'h0, rvalid[i][1]}, 32'h0);
    chk({nm, "_ram_addr"}, {2'b00, ram_addr[i]}, 32'h0);
    chk({nm, "_ram_wdata"}, ram_wdata[i], 32'h0);
    chk({nm, "_ram_be"}, {28'h0, ram_be[i]}, 32'h0);
    chk({nm, "_ram_wren"}, {31'h0, ram_wren[i]}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) set_m(i, m, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    tick(2);
    // Requests asserted under reset must produce nothing.
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) set_m(i, m, 1'b1, 1'b1, 30'h3F, 32'hFFFF0000, 4'hF);
    @(negedge clk);
    chk_outs_zero("reset", 0);
    chk_outs_zero("reset", 1);
    tick(1);
    for (int m = 0; m < 2; m++) set_m(1, m, 1'b0, 1'b0, '0, '0, '0);

    // Continuous reads from both, first cycle after reset release.
    rst = 1'b0;
    c = cyc;
    set_m(0, 0, 1'b1, 1'b0, 30'h40, 32'h0, 4'h0);
    set_m(0, 1, 1'b1, 1'b0, 30'h50, 32'h0, 4'h0);
    exp_gnt(c,     0, 0, 1'b0, 30'h40, 32'h0, 4'h0); exp_rv(c + 1, 0, 0, fmem(30'h40));
    exp_gnt(c + 2, 0, 1, 1'b0, 30'h50, 32'h0, 4'h0); exp_rv(c + 3, 0, 1, fmem(30'h50));
    exp_gnt(c + 4, 0, 0, 1'b0, 30'h40, 32'h0, 4'h0); exp_rv(c + 5, 0, 0, fmem(30'h40));
    exp_gnt(c + 6, 0, 1, 1'b0, 30'h50, 32'h0, 4'h0); exp_rv(c + 7, 0, 1, fmem(30'h50));
    tick(7);
    set_m(0, 0, 1'b0, 1'b0, '0, '0, '0);
    set_m(0, 1, 1'b0, 1'b0, '0, '0, '0);
    tick(1);

    // Continuous writes from both alternate every cycle.
    c = cyc;
    set_m(0, 0, 1'b1, 1'b1, 30'h60, 32'hA5A5A5A5, 4'hF);
    set_m(0, 1, 1'b1, 1'b1, 30'h70, 32'h5A5A5A5A, 4'h3);
    exp_gnt(c,     0, 0, 1'b1, 30'h60, 32'hA5A5A5A5, 4'hF);
    exp_gnt(c + 1, 0, 1, 1'b1, 30'h70, 32'h5A5A5A5A, 4'h3);
    exp_gnt(c + 2, 0, 0, 1'b1, 30'h60, 32'hA5A5A5A5, 4'hF);
    tick(3);
    set_m(0, 0, 1'b0, 1'b0, '0, '0, '0);
    set_m(0, 1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk_outs_zero("idle", 0);
    tick(1);

    // Single write, then a read whose successor waits out the rvalid cycle.
    c = cyc;
    set_m(0, 0, 1'b1, 1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
    exp_gnt(c, 0, 0, 1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
    tick(1);
    set_m(0, 0, 1'b0, 1'b0, '0, '0, '0);
    set_m(0, 1, 1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
    exp_gnt(c + 1, 0, 1, 1'b0, 30'h20, 32'h0, 4'h0);
    exp_rv(c + 2, 0, 1, 32'h12345678);
    tick(1);
    set_m(0, 1, 1'b0, 1'b0, '0, '0, '0);
    set_m(0, 0, 1'b1, 1'b0, 30'h30, 32'h0, 4'h0);
    exp_gnt(c + 3, 0, 0, 1'b0, 30'h30, 32'h0, 4'h0);
    exp_rv(c + 4, 0, 0, fmem(30'h30));
    tick(2);
    set_m(0, 0, 1'b0, 1'b0, '0, '0, '0);
    tick(2);

    // Latency-3 read with a competing request raised during WAIT.
    c = cyc;
    set_m(1, 0, 1'b1, 1'b0, 30'h80, 32'h0, 4'h0);
    exp_gnt(c, 1, 0, 1'b0, 30'h80, 32'h0, 4'h0);
    exp_rv(c + 3, 1, 0, fmem(30'h80));
    tick(1);
    set_m(1, 0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1, 1'b1, 1'b1, 30'h90, 32'h11223344, 4'hF);
    exp_gnt(c + 4, 1, 1, 1'b1, 30'h90, 32'h11223344, 4'hF);
    @(negedge clk);
    chk("wait_ram_addr", {2'b00, ram_addr[1]}, 32'h80);
    chk("wait_ram_wren", {31'h0, ram_wren[1]}, 32'h0);
    chk("wait_ram_wdata", ram_wdata[1], 32'h0);
    chk("wait_ram_be", {28'h0, ram_be[1]}, 32'h0);
    tick(4);
    set_m(1, 1, 1'b0, 1'b0, '0, '0, '0);

    // Reset pulse aborts an outstanding latency-3 read.
    c = cyc;
    set_m(1, 0, 1'b1, 1'b0, 30'hA0, 32'h0, 4'h0);
    exp_gnt(c, 1, 0, 1'b0, 30'hA0, 32'h0, 4'h0);
    tick(1);
    set_m(1, 0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1, 1'b1, 1'b0, 30'hB0, 32'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk_outs_zero("midwait_rst", 1);
    tick(1);
    rst = 1'b0;
    exp_gnt(c + 2, 1, 1, 1'b0, 30'hB0, 32'h0, 4'h0);
    exp_rv(c + 5, 1, 1, fmem(30'hB0));
    tick(1);
    set_m(1, 1, 1'b0, 1'b0, '0, '0, '0);
    tick(6);

    chk("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default 30: word-address width.
REQ-002 SHALL have parameter DataWidth, default 32: data width; byte-enable width is DataWidth/8.
REQ-003 SHALL have parameter ReadLatency, default 1, legal 1..4: RAM clocks from address to q.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 m0_req, m0_wr  in  1 each  requester 0 (CPU data port): request, write(1)/read(0).
REQ-007 m0_addr  in  AddrWidth; m0_wdata  in  DataWidth; m0_be  in  DataWidth/8.
REQ-008 m0_gnt  out  1  request accepted this cycle.
REQ-009 m0_rvalid  out  1; m0_rdata  out  DataWidth  read return.
REQ-010 m1_* SHALL mirror m0_* exactly, for requester 1 (UART loader/DMA).
REQ-011 ram_addr  out  AddrWidth; ram_wdata  out  DataWidth; ram_be  out  DataWidth/8; ram_wren  out  1  RAM port B drive.
REQ-012 ram_rdata  in  DataWidth  RAM port B q.

Function
REQ-013 SHALL implement two states, IDLE and WAIT; reset state IDLE.
REQ-014 In IDLE with exactly one req high, that requester SHALL win.
REQ-015 In IDLE with both req high, the winner SHALL be the requester not granted most recently (round-robin); pointer resets to "last = m1", so m0 wins the first tie.
REQ-016 The round-robin pointer SHALL update on every grant to the winner.
REQ-017 gnt SHALL be combinational: asserted for one cycle in the same cycle as the winner's req in IDLE; never to both requesters; never in WAIT.
REQ-018 In a grant cycle, ram_addr/ram_wdata/ram_be SHALL equal the winner's inputs; ram_wren SHALL equal winner's wr.
REQ-019 Requesters hold req/wr/addr/wdata/be stable until gnt; the arbiter SHALL NOT register write data.
REQ-020 Write grant: completes in the grant cycle; state stays IDLE; a new grant is possible the next cycle.
REQ-021 Read grant: SHALL register owner and address, load a down-counter with ReadLatency, and enter WAIT.
REQ-022 In WAIT: ram_wren=0, ram_addr = registered address, ram_wdata=0, ram_be=0; counter decrements each cycle.
REQ-023 The owner's rvalid SHALL assert for exactly one cycle, ReadLatency cycles after the grant cycle (cycle T+ReadLatency); rdata = ram_rdata in that cycle; state returns to IDLE on the following edge.
REQ-024 No grant SHALL be issued in the rvalid cycle; read throughput is one per ReadLatency+1 cycles.
REQ-025 Non-owner rvalid SHALL be 0 and its rdata SHALL be 0; owner rdata SHALL be 0 when rvalid=0.
REQ-026 In IDLE with no req: ram_wren=0, ram_addr=0, ram_wdata=0, ram_be=0.
REQ-027 A req arriving or held during WAIT SHALL be served in IDLE by the normal rules; no request is lost.

Reset
REQ-028 On rst: state=IDLE, counter=0, pointer=m1, registered owner/address=0; all outputs 0 (gnt, rvalid, rdata, ram_*) while rst is high.
REQ-029 rst asserted mid-WAIT SHALL abort the read; no rvalid SHALL be produced afterwards for it.
REQ-030 After rst deasserts, the first grant SHALL be possible in the first clock cycle.

Verification
REQ-031 m0 write addr=0x10, wdata=0xDEADBEEF, be=0xF -> same cycle m0_gnt=1, ram_wren=1, ram_addr=0x10; state stays IDLE.
REQ-032 m1 read addr=0x20, ram returns 0x12345678, ReadLatency=1 -> m1_gnt at T, m1_rvalid=1 with m1_rdata=0x12345678 at T+1, m0_rvalid=0, next grant no earlier than T+2.
REQ-033 Both req continuous reads after reset -> grant order m0, m1, m0, m1; each pair of grants separated by ReadLatency+1 cycles.
REQ-034 Both req continuous writes -> grants alternate every cycle m0, m1, m0; ram_wren=1 each cycle.
REQ-035 ReadLatency=3, m0 read granted at T, rst pulsed at T+1 -> no rvalid at T+3; all outputs 0 during rst; grant possible in the first cycle after release.
REQ-036 m0 read in WAIT while m1 raises req -> m1_gnt=0 throughout WAIT and rvalid cycle, m1_gnt=1 in first IDLE cycle.
